// File: rtl/rb_fifo_pkg.sv
// Shared types for the ring-buffer FIFO reader.
// Holds the reader FSM state encoding and the default data MSB.
package rb_fifo_pkg;

  localparam int RB_MSBD = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } state_t;

endpackage

// File: rtl/rb_fifo_reader_if.sv
// Reader bus: FIFO consumer side plus the downstream valid/ready stream.
// master = reader (drives fifo_pop, out_*); slave = FIFO + sink side.
interface rb_fifo_reader_if #(
  parameter int MSBD = 3
);

  logic [MSBD:0] fifo_dout;
  logic          fifo_empty;
  logic          fifo_push;
  logic          fifo_pop;
  logic [MSBD:0] out_data;
  logic          out_valid;
  logic          out_ready;

  modport master (
    input  fifo_dout, fifo_empty, fifo_push, out_ready,
    output fifo_pop, out_data, out_valid
  );

  modport slave (
    output fifo_dout, fifo_empty, fifo_push, out_ready,
    input  fifo_pop, out_data, out_valid
  );

endinterface

// File: rtl/rb_skid2.sv
// Two-entry in-order buffer; e0 is always the oldest word.
// Ports: clock, rst, wr/wdata (push), rd (pop), rdata (head), occ.
module rb_skid2 #(
  parameter int MSBD = 3
) (
  input  logic          clock,
  input  logic          rst,
  input  logic          wr,
  input  logic [MSBD:0] wdata,
  input  logic          rd,
  output logic [MSBD:0] rdata,
  output logic [1:0]    occ
);

  logic [MSBD:0] e0;
  logic [MSBD:0] e1;

  assign rdata = e0;

  always_ff @(posedge clock) begin
    if (rst) begin
      e0  <= '0;
      e1  <= '0;
      occ <= '0;
    end else begin
      unique case ({wr, rd})
        2'b10: begin
          if (occ == 2'd0) e0 <= wdata;
          else             e1 <= wdata;
          if (occ != 2'd2) occ <= occ + 2'd1;
        end
        2'b01: begin
          e0 <= e1;
          if (occ != 2'd0) occ <= occ - 2'd1;
        end
        2'b11: begin
          // Full and both: survivor moves up, new word goes behind it.
          if (occ == 2'd2) begin
            e0 <= e1;
            e1 <= wdata;
          end else begin
            e0 <= wdata;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/rb_fifo_reader.sv
// Consumer-side controller: pops the FIFO head into a 2-entry skid
// buffer and re-presents it as a valid/ready stream.
// Ports: clock, rst, en, bus (reader_if.master), rd_count, busy.
module rb_fifo_reader
  import rb_fifo_pkg::*;
#(
  parameter int MSBD = RB_MSBD,
  parameter int CNTW = 8
) (
  input  logic            clock,
  input  logic            rst,
  input  logic            en,
  rb_fifo_reader_if.master bus,
  output logic [CNTW-1:0] rd_count,
  output logic            busy
);

  state_t        state;
  logic [1:0]    occ;
  logic [MSBD:0] head;
  logic          acc;
  logic          room;
  logic          pop;
  logic          active;

  assign acc    = bus.out_valid & bus.out_ready;
  assign room   = (occ < 2'd2) | acc;
  assign active = (state == STREAM) | (state == DRAIN);

  // The FIFO drops a pop that coincides with a push, so never
  // pop then or the captured word would be seen twice.
  assign pop = active & ~bus.fifo_empty & ~bus.fifo_push
             & room & ~rst;

  assign bus.fifo_pop  = pop;
  assign bus.out_valid = (occ != 2'd0);
  assign bus.out_data  = head;
  assign busy          = (state != IDLE);

  rb_skid2 #(.MSBD(MSBD)) u_skid (
    .clock (clock),
    .rst   (rst),
    .wr    (pop),
    .wdata (bus.fifo_dout),
    .rd    (acc),
    .rdata (head),
    .occ   (occ)
  );

  always_ff @(posedge clock) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      unique case (state)
        IDLE:    if (en) state <= STREAM;
        STREAM:  if (!en) state <= DRAIN;
        DRAIN: begin
          if (en)                     state <= STREAM;
          else if (occ == 2'd0 && !pop) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (rst)      rd_count <= '0;
    else if (acc) rd_count <= rd_count + CNTW'(1);
  end

endmodule

// File: tb/tb_rb_fifo_reader.sv
// Bench for rb_fifo_reader with a 16-deep 4-bit ring-buffer FIFO model.
// Scoreboard queue filled on accepted pushes, drained by a stream monitor.
module tb_rb_fifo_reader;

  logic       clock = 1'b0;
  logic       rst   = 1'b1;
  logic       en    = 1'b0;
  logic       push  = 1'b0;
  logic [3:0] din   = '0;
  logic       ready = 1'b0;
  logic [7:0] rd_count;
  logic       busy;

  int total = 0;
  int bad   = 0;
  int pops  = 0;

  logic [3:0] exp_q[$];

  logic [3:0] mem[16];
  logic [3:0] wp = '0;
  logic [3:0] rp = '0;
  logic [4:0] cnt = '0;

  always #5 clock = ~clock;

  rb_fifo_reader_if #(.MSBD(3)) bus ();

  assign bus.fifo_dout  = mem[rp];
  assign bus.fifo_empty = (cnt == 5'd0);
  assign bus.fifo_push  = push;
  assign bus.out_ready  = ready;

  rb_fifo_reader #(.MSBD(3), .CNTW(8)) dut (
    .clock    (clock),
    .rst      (rst),
    .en       (en),
    .bus      (bus),
    .rd_count (rd_count),
    .busy     (busy)
  );

  // Ring-buffer FIFO: push has priority, a pop during a push is ignored.
  always @(posedge clock) begin
    if (rst) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else if (push) begin
      if (cnt != 5'd16) begin
        mem[wp] <= din;
        wp      <= wp + 4'd1;
        cnt     <= cnt + 5'd1;
      end
    end else if (bus.fifo_pop && cnt != 5'd0) begin
      rp   <= rp + 4'd1;
      cnt  <= cnt - 5'd1;
      pops <= pops + 1;
    end
  end

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Stream monitor: every accepted beat must match the oldest pushed word.
  always @(negedge clock) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL stream_extra: got %0d expected none", bus.out_data);
      end else begin
        logic [3:0] e;
        e = exp_q.pop_front();
        if (bus.out_data !== e) begin
          bad++;
          $display("FAIL stream_data: got %0d expected %0d",
                   bus.out_data, e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push_word(input logic [3:0] d);
    push = 1'b1;
    din  = d;
    if (cnt != 5'd16) exp_q.push_back(d);
    tick();
  endtask

  task automatic wait_count(input int target, input int budget,
                            input string nm);
    int n = 0;
    while (int'(rd_count) != target && n < budget) begin
      tick();
      n++;
    end
    check(nm, int'(rd_count), target);
  endtask

  task automatic wait_idle(input int budget, input string nm);
    int n = 0;
    while (busy && n < budget) begin
      tick();
      n++;
    end
    check(nm, int'(busy), 0);
  endtask

  initial begin
    int p0;

    // 1. reset
    repeat (2) tick();
    @(negedge clock);
    check("rst_valid", int'(bus.out_valid), 0);
    check("rst_pop", int'(bus.fifo_pop), 0);
    check("rst_count", int'(rd_count), 0);
    check("rst_busy", int'(busy), 0);
    @(posedge clock);
    #1;
    rst = 1'b0;

    // 2. three words streamed back-to-back
    push_word(4'd1);
    push_word(4'd2);
    push_word(4'd3);
    push = 1'b0;
    en    = 1'b1;
    ready = 1'b1;
    repeat (4) tick();
    check("t2_count_b2b", int'(rd_count), 2);
    tick();
    check("t2_count", int'(rd_count), 3);
    check("t2_empty", int'(bus.fifo_empty), 1);

    // 3. full FIFO, stalled sink: only two pops
    en    = 1'b0;
    ready = 1'b0;
    wait_idle(10, "t3_idle");
    for (int i = 0; i < 16; i++) push_word(4'(15 - i));
    push = 1'b0;
    check("t3_full", int'(cnt), 16);
    p0 = pops;
    en = 1'b1;
    repeat (6) tick();
    check("t3_pops", pops - p0, 2);
    check("t3_cnt", int'(cnt), 14);
    check("t3_valid", int'(bus.out_valid), 1);
    ready = 1'b1;
    wait_count(19, 60, "t3_count");

    // 4. push held for 4 cycles: reader must not pop
    for (int i = 0; i < 4; i++) begin
      push = 1'b1;
      din  = 4'(9 + i);
      exp_q.push_back(4'(9 + i));
      @(negedge clock);
      check("t4_nopop", int'(bus.fifo_pop), 0);
      tick();
    end
    push = 1'b0;
    wait_count(23, 20, "t4_count");

    // 5. drop en mid-stream: DRAIN delivers the rest then idles
    en    = 1'b0;
    ready = 1'b0;
    wait_idle(10, "t5_idle0");
    push_word(4'd7);
    push_word(4'd3);
    push_word(4'd5);
    push_word(4'd1);
    push_word(4'd14);
    push  = 1'b0;
    en    = 1'b1;
    ready = 1'b1;
    wait_count(25, 20, "t5_two");
    en = 1'b0;
    wait_idle(30, "t5_idle");
    check("t5_count", int'(rd_count), 28);
    check("t5_empty", int'(bus.fifo_empty), 1);
    check("t5_sb_empty", exp_q.size(), 0);

    // 6. reset with two buffered words
    ready = 1'b0;
    en    = 1'b1;
    push_word(4'd6);
    push_word(4'd8);
    push_word(4'd4);
    push = 1'b0;
    repeat (4) tick();
    check("t6_cnt_pre", int'(cnt), 1);
    check("t6_valid_pre", int'(bus.out_valid), 1);
    rst = 1'b1;
    exp_q.delete();
    tick();
    check("t6_valid", int'(bus.out_valid), 0);
    check("t6_data", int'(bus.out_data), 0);
    check("t6_count", int'(rd_count), 0);
    check("t6_busy", int'(busy), 0);
    check("t6_empty", int'(bus.fifo_empty), 1);
    rst = 1'b0;
    en  = 1'b0;
    repeat (2) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
